// File: rtl/mmio_io_responder_pkg.sv
// Register map for the MMIO I/O responder: window width, byte offsets,
// the status bit position and address-decode helpers.
package io_map_pkg;

  localparam int unsigned WIN_BITS = 5;

  localparam logic [4:0] OFF_OPR1   = 5'h00;
  localparam logic [4:0] OFF_OPR2   = 5'h04;
  localparam logic [4:0] OFF_RESULT = 5'h08;
  localparam logic [4:0] OFF_STATUS = 5'h0C;
  localparam logic [4:0] OFF_CYCLE  = 5'h10;

  localparam int unsigned CHG_BIT = 0;

  // Word index within the window (byte offset >> 2)
  typedef enum logic [2:0] {
    REG_OPR1   = OFF_OPR1[4:2],
    REG_OPR2   = OFF_OPR2[4:2],
    REG_RESULT = OFF_RESULT[4:2],
    REG_STATUS = OFF_STATUS[4:2],
    REG_CYCLE  = OFF_CYCLE[4:2],
    REG_RSVD5  = 3'd5,
    REG_RSVD6  = 3'd6,
    REG_RSVD7  = 3'd7
  } reg_idx_e;

  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:WIN_BITS] == base[31:WIN_BITS];
  endfunction

  function automatic reg_idx_e reg_idx(input logic [31:0] addr);
    return reg_idx_e'(addr[WIN_BITS-1:2]);
  endfunction

endpackage

// File: rtl/mmio_io_responder_if.sv
// DMEM-side load/store bus between the Core (master) and the responder (slave).
interface mmio_io_responder_if;
  logic        we;
  logic [31:0] ask_addr;
  logic [31:0] fetch_addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;

  modport master (output we, ask_addr, fetch_addr, wdata, input rdata, hit);
  modport slave  (input we, ask_addr, fetch_addr, wdata, output rdata, hit);
endinterface

// File: rtl/mmio_io_responder_debounce.sv
// io_debounce: 2-flop synchronizer followed by a stability counter. A new
// synced value is accepted into db only after DEBOUNCE_CYCLES consecutive
// cycles of differing from db; chg_pulse marks the accepting edge.
module io_debounce #(
  parameter int unsigned W               = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] din,
  output logic [W-1:0] db,
  output logic         chg_pulse
);

  localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0] s1;
  logic [W-1:0] syn;
  logic [15:0]  cnt;

  // Two-stage synchronizer for the asynchronous switch inputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1  <= '0;
      syn <= '0;
    end else begin
      s1  <= din;
      syn <= s1;
    end
  end

  // Pulse is combinational so the status flag sets on the same edge db updates
  always_comb chg_pulse = (syn != db) && (cnt == LAST);

  // Stability counter and accepted value
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
      db  <= '0;
    end else if (syn == db) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      db  <= syn;
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/mmio_io_responder.sv
// mmio_io_responder: 32-byte MMIO window on the Core's DMEM bus exposing
// debounced operand switches, a writable result register, a W1C change flag
// and (when IO_CYCLE_COUNTER_EN is defined) a free-running cycle counter.
// Reads are combinational from fetch_addr; writes commit on the clock edge.
module mmio_io_responder
  import io_map_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  mmio_io_responder_if.slave   bus,
  input  logic [7:0]           opr1,
  input  logic [7:0]           opr2,
  output logic [15:0]          result
);

  logic [7:0] opr1_db;
  logic [7:0] opr2_db;
  logic       chg1_pulse;
  logic       chg2_pulse;
  logic       chg;
  logic       rd_hit;
  logic       wr_hit;
  reg_idx_e   rd_idx;
  reg_idx_e   wr_idx;
  logic [31:0] rdata_c;

`ifdef IO_CYCLE_COUNTER_EN
  logic [31:0] cycle;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.ask_addr[1:0], bus.fetch_addr[1:0], bus.wdata[31:16]};

  io_debounce #(.W(8), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_opr1 (
    .clk       (clk),
    .resetn    (resetn),
    .din       (opr1),
    .db        (opr1_db),
    .chg_pulse (chg1_pulse)
  );

  io_debounce #(.W(8), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_opr2 (
    .clk       (clk),
    .resetn    (resetn),
    .din       (opr2),
    .db        (opr2_db),
    .chg_pulse (chg2_pulse)
  );

  // Address decode: reads on fetch_addr, writes on ask_addr
  always_comb begin
    rd_hit = in_window(bus.fetch_addr, BASE_ADDR);
    wr_hit = bus.we && in_window(bus.ask_addr, BASE_ADDR);
    rd_idx = reg_idx(bus.fetch_addr);
    wr_idx = reg_idx(bus.ask_addr);
  end

  // Result register written through offset 0x08
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result <= '0;
    end else if (wr_hit && wr_idx == REG_RESULT) begin
      result <= bus.wdata[15:0];
    end
  end

  // Change flag: set from either bank, W1C at offset 0x0C, set has priority
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chg <= 1'b0;
    end else if (chg1_pulse || chg2_pulse) begin
      chg <= 1'b1;
    end else if (wr_hit && wr_idx == REG_STATUS && bus.wdata[CHG_BIT]) begin
      chg <= 1'b0;
    end
  end

`ifdef IO_CYCLE_COUNTER_EN
  // Free-running cycle counter, loadable via offset 0x10
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cycle <= '0;
    end else if (wr_hit && wr_idx == REG_CYCLE) begin
      cycle <= bus.wdata;
    end else begin
      cycle <= cycle + 32'd1;
    end
  end
`endif

  // Zero-latency read mux; unmapped offsets and misses read zero
  always_comb begin
    rdata_c = '0;
    if (rd_hit) begin
      case (rd_idx)
        REG_OPR1:   rdata_c = {24'b0, opr1_db};
        REG_OPR2:   rdata_c = {24'b0, opr2_db};
        REG_RESULT: rdata_c = {16'b0, result};
        REG_STATUS: rdata_c[CHG_BIT] = chg;
`ifdef IO_CYCLE_COUNTER_EN
        REG_CYCLE:  rdata_c = cycle;
`endif
        default:    rdata_c = '0;
      endcase
    end
  end

  assign bus.rdata = rdata_c;
  assign bus.hit   = rd_hit;

endmodule

// File: tb/tb_mmio_io_responder.sv
// Directed bench for mmio_io_responder with DEBOUNCE_CYCLES=4, BASE 0x1000.
module tb_mmio_io_responder;

  logic        clk;
  logic        resetn;
  logic [7:0]  opr1;
  logic [7:0]  opr2;
  logic [15:0] result;

  int unsigned total;
  int unsigned bad;

  mmio_io_responder_if bus ();

  mmio_io_responder #(.BASE_ADDR(32'h0000_1000), .DEBOUNCE_CYCLES(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .opr1   (opr1),
    .opr2   (opr2),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    bus.fetch_addr = addr;
    #1;
    data = bus.rdata;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.we       = 1'b1;
    bus.ask_addr = addr;
    bus.wdata    = data;
    tick(1);
    bus.we       = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    total = 0;
    bad   = 0;
    resetn = 1'b0;
    opr1 = 8'hA5;
    opr2 = 8'h00;
    bus.we = 1'b0;
    bus.ask_addr = '0;
    bus.fetch_addr = '0;
    bus.wdata = '0;

    // Reset held
    #12;
    check("rst_result", {16'b0, result}, 32'h0);
    rd(32'h0000_1000, d); check("rst_opr1", d, 32'h0);
    check("rst_hit", {31'b0, bus.hit}, 32'h1);
    rd(32'h0000_100C, d); check("rst_chg", d, 32'h0);

    // Release: sync takes 2 edges, debounce 4 more
    @(negedge clk);
    resetn = 1'b1;
    tick(5);
    rd(32'h0000_1000, d); check("opr1_before_accept", d, 32'h0);
    tick(1);
    rd(32'h0000_1000, d); check("opr1_accept", d, 32'h0000_00A5);
    rd(32'h0000_100C, d); check("chg_after_opr1", d, 32'h1);

    wr(32'h0000_100C, 32'h1);
    rd(32'h0000_100C, d); check("chg_clear", d, 32'h0);

    // Glitch of 3 cycles on opr2 is rejected
    opr2 = 8'h3C;
    tick(3);
    opr2 = 8'h00;
    tick(8);
    rd(32'h0000_1004, d); check("glitch_opr2", d, 32'h0);
    rd(32'h0000_100C, d); check("glitch_chg", d, 32'h0);

    // Stable change on opr2 is accepted on the 6th edge
    opr2 = 8'h3C;
    tick(5);
    rd(32'h0000_1004, d); check("opr2_before_accept", d, 32'h0);
    tick(1);
    rd(32'h0000_1004, d); check("opr2_accept", d, 32'h0000_003C);
    rd(32'h0000_100C, d); check("chg_after_opr2", d, 32'h1);

    // Result write; read during the write cycle sees the old value
    bus.we = 1'b1;
    bus.ask_addr = 32'h0000_1008;
    bus.wdata = 32'hDEAD_1234;
    rd(32'h0000_1008, d); check("result_old_during_wr", d, 32'h0);
    tick(1);
    bus.we = 1'b0;
    check("result_port", {16'b0, result}, 32'h0000_1234);
    rd(32'h0000_1008, d); check("result_read", d, 32'h0000_1234);

    // Out-of-window write ignored, out-of-window read misses
    wr(32'h0000_2008, 32'h0000_5555);
    check("result_miss_wr", {16'b0, result}, 32'h0000_1234);
    rd(32'h0000_2008, d); check("miss_rdata", d, 32'h0);
    check("miss_hit", {31'b0, bus.hit}, 32'h0);

    // Writes to RO and reserved offsets
    wr(32'h0000_1000, 32'h0000_00FF);
    rd(32'h0000_1000, d); check("ro_opr1", d, 32'h0000_00A5);
    wr(32'h0000_1014, 32'hFFFF_FFFF);
    rd(32'h0000_1014, d); check("rsvd_read", d, 32'h0);
    rd(32'h0000_101F, d); check("rsvd_last", d, 32'h0);

    // CHG set/clear race: clear lands on the accepting edge of opr1
    wr(32'h0000_100C, 32'h1);
    rd(32'h0000_100C, d); check("chg_clear2", d, 32'h0);
    opr1 = 8'h5A;
    tick(5);
    wr(32'h0000_100C, 32'h1);
    rd(32'h0000_100C, d); check("chg_race_set_wins", d, 32'h1);
    rd(32'h0000_1000, d); check("opr1_5a", d, 32'h0000_005A);
    wr(32'h0000_100C, 32'h0);
    rd(32'h0000_100C, d); check("chg_w0_noeffect", d, 32'h1);
    wr(32'h0000_100C, 32'h1);
    rd(32'h0000_100C, d); check("chg_w1_clear", d, 32'h0);

    // Cycle counter
`ifdef IO_CYCLE_COUNTER_EN
    wr(32'h0000_1010, 32'hFFFF_FFFE);
    rd(32'h0000_1010, d); check("cycle_load", d, 32'hFFFF_FFFE);
    tick(1);
    rd(32'h0000_1010, d); check("cycle_max", d, 32'hFFFF_FFFF);
    tick(1);
    rd(32'h0000_1010, d); check("cycle_wrap", d, 32'h0);
`else
    wr(32'h0000_1010, 32'hFFFF_FFFE);
    rd(32'h0000_1010, d); check("cycle_absent", d, 32'h0);
`endif

    // Mid-operation asynchronous reset
    wr(32'h0000_1008, 32'h0000_00FF);
    check("result_ff", {16'b0, result}, 32'h0000_00FF);
    opr2 = 8'h00;
    tick(6);
    rd(32'h0000_100C, d); check("chg_pre_reset", d, 32'h1);
    opr2 = 8'h3C;
    tick(4);
    #2;
    resetn = 1'b0;
    #1;
    check("async_result", {16'b0, result}, 32'h0);
    rd(32'h0000_100C, d); check("async_chg", d, 32'h0);
    rd(32'h0000_1000, d); check("async_opr1", d, 32'h0);
    resetn = 1'b1;
    tick(5);
    rd(32'h0000_1004, d); check("restart_before", d, 32'h0);
    tick(1);
    rd(32'h0000_1004, d); check("restart_accept", d, 32'h0000_003C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
